// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/func codes, fetch state encoding, default reset PC.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_AND = 6'h24;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  // J/JAL target: region bits come from the sequential PC, not the current one.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] instr_idx);
    return {pc_plus4[31:28], instr_idx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC select: J/JAL immediate > JR register > taken branch > sequential.
// Latency: combinational.
// Backpressure: none; the caller decides when next_pc is consumed.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_idx,
  input  logic [31:0] branch_imm,
  input  logic [31:0] jr_target,
  input  logic        pc_src,
  input  logic        pc_jump,
  input  logic        jump_sel,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (pc_jump && jump_sel)
      next_pc = jump_target(pc_plus4, instr_idx);
    else if (pc_jump)
      next_pc = jr_target;
    else if (pc_src)
      next_pc = pc_plus4 + (branch_imm << 2);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC owner and instruction fetcher; optional misalign trap under FETCH_MISALIGN_TRAP_EN.
// Latency: imem_ack to instr_valid is 1 cycle; retire to next imem_req is 1 cycle.
// Backpressure: instr held in HOLD until instr_ready; imem request held until imem_ack.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          MAX_WAIT = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             pc_src,
  input  logic             pc_jump,
  input  logic             jump_sel,
  input  logic [31:0]      branch_imm,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_timeout,
  output logic [CNT_W-1:0] instr_count
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q;
  logic [31:0]        instr_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        next_pc;
  logic [31:0]        pc_load;
  logic               retire;
  logic               retire_ok;

  assign pc_plus4 = pc_q + 32'd4;
  assign retire   = (state_q == HOLD) && instr_ready;

  next_pc_calc u_next_pc_calc (
    .pc_plus4   (pc_plus4),
    .instr_idx  (instr_q[25:0]),
    .branch_imm (branch_imm),
    .jr_target  (jr_target),
    .pc_src     (pc_src),
    .pc_jump    (pc_jump),
    .jump_sel   (jump_sel),
    .next_pc    (next_pc)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned    = |next_pc[1:0];
  assign retire_ok     = retire && !misaligned;
  assign pc_load       = next_pc;
  assign misalign_trap = (state_q == TRAP);
`else
  assign retire_ok = retire;
  assign pc_load   = {next_pc[31:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: if (imem_ack) state_d = HOLD;
      HOLD: begin
        if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_d = misaligned ? TRAP : FETCH;
`else
          state_d = FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      TRAP:    state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Wait counter saturates at MAX_WAIT; the timeout flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (state_q == FETCH) begin
        if (imem_ack) begin
          instr_q <= imem_rdata;
        end else if (wait_q != WAIT_MAX) begin
          wait_q <= wait_q + WAIT_W'(1);
          if (wait_q == WAIT_MAX - WAIT_W'(1)) timeout_q <= 1'b1;
        end
      end
      if (retire_ok) begin
        pc_q    <= pc_load;
        count_q <= count_q + CNT_W'(1);
        wait_q  <= '0;
      end
    end
  end

  assign pc            = pc_q;
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign fetch_timeout = timeout_q;
  assign instr_count   = count_q;

endmodule
